// File: rtl/count_display_driver.sv
// count_display_driver
// Converts a 9-bit binary count to three BCD digits with a sequential
// shift-add-3 engine. Drives a 4-digit common-anode multiplexed 7-segment
// display using registered active-low anode and segment outputs.
// Leading zeros are blanked. A one-cycle blank at every digit switch
// suppresses ghosting.
module count_display_driver #(
    parameter int REFRESH_DIV = 4096
) (
    input  logic       system_clock,
    input  logic       system_reset,
    input  logic [8:0] count,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int                DIV_W    = $clog2(REFRESH_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    // BCD correction: a nibble of 5 or more would overflow past 9 once doubled.
    function automatic logic [3:0] add3(input logic [3:0] nib);
        logic [3:0] res;
        if (nib >= 4'd5) begin
            res = nib + 4'd3;
        end else begin
            res = nib;
        end
        return res;
    endfunction

    // Active-low segment pattern {g,f,e,d,c,b,a}; any non-decimal code is blank.
    function automatic logic [6:0] glyph(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = 7'h40;
            4'd1:    pat = 7'h79;
            4'd2:    pat = 7'h24;
            4'd3:    pat = 7'h30;
            4'd4:    pat = 7'h19;
            4'd5:    pat = 7'h12;
            4'd6:    pat = 7'h02;
            4'd7:    pat = 7'h78;
            4'd8:    pat = 7'h00;
            4'd9:    pat = 7'h10;
            default: pat = 7'h7F;
        endcase
        return pat;
    endfunction

    state_t             state_q, state_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [8:0]         shift_q, shift_d;
    logic [11:0]        acc_q, acc_d;
    logic [11:0]        disp_q, disp_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [1:0]         slot_q, slot_d;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q;
    logic [10:0]        acc_adj_s;
    logic [3:0]         digit_s;
    logic               show_s;

    // Conversion FSM: sample in LOAD, nine add-3/shift steps, then publish.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        acc_d     = acc_q;
        disp_d    = disp_q;
        // The corrected hundreds nibble never reaches bit 3 before the final
        // shift, so only the low 11 bits are carried into the shift.
        acc_adj_s = 11'({add3(acc_q[11:8]), add3(acc_q[7:4]), add3(acc_q[3:0])});
        case (state_q)
            ST_LOAD: begin
                shift_d   = count;
                acc_d     = 12'd0;
                bit_cnt_d = 4'd0;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                acc_d   = {acc_adj_s, shift_q[8]};
                shift_d = {shift_q[7:0], 1'b0};
                if (bit_cnt_q == 4'd8) begin
                    state_d = ST_UPDATE;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            ST_UPDATE: begin
                disp_d  = acc_q;
                state_d = ST_LOAD;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // Refresh divider and slot index; the slot advances on divider wrap.
    always_comb begin
        div_d  = div_q;
        slot_d = slot_q;
        if (div_q == DIV_LAST) begin
            div_d  = '0;
            slot_d = slot_q + 2'd1;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    // Digit select with leading-zero blanking, then anode/segment decode.
    always_comb begin
        digit_s = 4'd0;
        show_s  = 1'b0;
        an_d    = 4'b1111;
        seg_d   = 7'h7F;
        case (slot_q)
            2'd0: begin
                digit_s = disp_q[3:0];
                show_s  = 1'b1;
            end
            2'd1: begin
                digit_s = disp_q[7:4];
                show_s  = (disp_q[7:4] != 4'd0) || (disp_q[11:8] != 4'd0);
            end
            2'd2: begin
                digit_s = disp_q[11:8];
                show_s  = (disp_q[11:8] != 4'd0);
            end
            default: begin
                digit_s = 4'd0;
                show_s  = 1'b0;
            end
        endcase
        if ((div_q == '0) || (slot_q == 2'd3)) begin
            an_d  = 4'b1111;
            seg_d = 7'h7F;
        end else begin
            an_d  = ~(4'b0001 << slot_q);
            if (show_s) begin
                seg_d = glyph(digit_s);
            end else begin
                seg_d = 7'h7F;
            end
        end
    end

    // State and output registers; reset blanks the display immediately.
    always_ff @(posedge system_clock or posedge system_reset) begin
        if (system_reset) begin
            state_q   <= ST_LOAD;
            bit_cnt_q <= 4'd0;
            shift_q   <= 9'd0;
            acc_q     <= 12'd0;
            disp_q    <= 12'd0;
            div_q     <= '0;
            slot_q    <= 2'd0;
            an_q      <= 4'b1111;
            seg_q     <= 7'h7F;
            dp_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            acc_q     <= acc_d;
            disp_q    <= disp_d;
            div_q     <= div_d;
            slot_q    <= slot_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= 1'b1;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_count_display_driver.sv
// Directed testbench for count_display_driver. Two instances share the
// stimulus: one with an 8-cycle slot, one with a 2-cycle slot.
module tb_count_display_driver;

    logic       clk;
    logic       rst;
    logic [8:0] count;
    logic [3:0] an8, an2;
    logic [6:0] seg8, seg2;
    logic       dp8, dp2;

    int k;
    int n_cmp;
    int n_err;

    count_display_driver #(.REFRESH_DIV(8)) dut8 (
        .system_clock (clk),
        .system_reset (rst),
        .count        (count),
        .an           (an8),
        .seg          (seg8),
        .dp           (dp8)
    );

    count_display_driver #(.REFRESH_DIV(2)) dut2 (
        .system_clock (clk),
        .system_reset (rst),
        .count        (count),
        .an           (an2),
        .seg          (seg2),
        .dp           (dp2)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [6:0] ref_glyph(input int d);
        case (d)
            0:       return 7'h40;
            1:       return 7'h79;
            2:       return 7'h24;
            3:       return 7'h30;
            4:       return 7'h19;
            5:       return 7'h12;
            6:       return 7'h02;
            7:       return 7'h78;
            8:       return 7'h00;
            9:       return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Output after edge k reflects divider/slot as they stood after edge k-1.
    function automatic logic [3:0] exp_an(input int div, input int kk);
        int d, s;
        d = (kk - 1) % div;
        s = ((kk - 1) / div) % 4;
        if (d == 0 || s == 3) return 4'b1111;
        case (s)
            0:       return 4'b1110;
            1:       return 4'b1101;
            default: return 4'b1011;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int div, input int kk, input int val);
        int d, s;
        d = (kk - 1) % div;
        s = ((kk - 1) / div) % 4;
        if (d == 0 || s == 3) return 7'h7F;
        case (s)
            0:       return ref_glyph(val % 10);
            1:       return (val < 10) ? 7'h7F : ref_glyph((val / 10) % 10);
            default: return (val < 100) ? 7'h7F : ref_glyph(val / 100);
        endcase
    endfunction

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an8"},  12'(an8),  12'h00F);
        check({tag, "_seg8"}, 12'(seg8), 12'h07F);
        check({tag, "_dp8"},  12'(dp8),  12'h001);
        check({tag, "_an2"},  12'(an2),  12'h00F);
        check({tag, "_seg2"}, 12'(seg2), 12'h07F);
        check({tag, "_dp2"},  12'(dp2),  12'h001);
    endtask

    // One clock edge; optionally compare both instances against the model.
    task automatic tick(input bit chk, input int val);
        @(posedge clk);
        #1;
        k++;
        if (chk) begin
            check($sformatf("an8@%0d", k),  12'(an8),  12'(exp_an(8, k)));
            check($sformatf("seg8@%0d", k), 12'(seg8), 12'(exp_seg(8, k, val)));
            check($sformatf("dp8@%0d", k),  12'(dp8),  12'h001);
            check($sformatf("an2@%0d", k),  12'(an2),  12'(exp_an(2, k)));
            check($sformatf("seg2@%0d", k), 12'(seg2), 12'(exp_seg(2, k, val)));
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        k     = 0;
        rst   = 1'b1;
        count = 9'd0;
        #100;
        check_reset_outputs("por");
        check("por_disp", dut8.disp_q, 12'h000);
        rst = 1'b0;

        // count = 0: blank at edge 1, "0" lit from edge 2, upper digits blank.
        repeat (32) tick(1'b1, 0);

        count = 9'd511;
        repeat (12) tick(1'b0, 0);
        repeat (32) tick(1'b1, 511);

        count = 9'd105;
        repeat (12) tick(1'b0, 0);
        repeat (32) tick(1'b1, 105);

        count = 9'd7;
        repeat (12) tick(1'b0, 0);
        repeat (32) tick(1'b1, 7);

        // 37 sampled at the LOAD on edge 166, changed to 200 in its 4th SHIFT.
        count = 9'd37;
        repeat (5) tick(1'b0, 0);
        count = 9'd200;
        repeat (6) tick(1'b0, 0);
        check("disp_pre37", dut8.disp_q, 12'h007);
        tick(1'b0, 0);
        check("disp_37", dut8.disp_q, 12'h037);
        repeat (10) tick(1'b1, 37);
        check("disp_37_held", dut8.disp_q, 12'h037);
        tick(1'b1, 37);
        check("disp_200", dut8.disp_q, 12'h200);
        repeat (32) tick(1'b1, 200);

        // Asynchronous reset between edges, mid-scan.
        #4;
        rst = 1'b1;
        #1;
        check_reset_outputs("arst");
        check("arst_disp", dut8.disp_q, 12'h000);
        @(posedge clk);
        #1;
        check_reset_outputs("arst_hold");
        @(negedge clk);
        rst = 1'b0;
        k   = 0;
        repeat (11) tick(1'b1, 0);
        repeat (32) tick(1'b1, 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
